// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor computing a - b - bi, one bit per cycle, LSB first.
module sub_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             bo,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic brw_q, brw_d, bo_q, bo_d;
  logic ai, bb, dbit, brw_nx, last;
  always_comb begin
    ai = a_q[cnt_q];
    bb = b_q[cnt_q];
    dbit = ai ^ bb ^ brw_q;
    brw_nx = (~ai & bb) | (~(ai ^ bb) & brw_q);
    last = cnt_q == CW'(WIDTH - 1);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sh_d = sh_q;
    r_d = r_q;
    cnt_d = cnt_q;
    brw_d = brw_q;
    bo_d = bo_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        brw_d = bi;
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sh_d = {dbit, sh_q[WIDTH-1:1]};
        brw_d = brw_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          r_d = sh_d;
          bo_d = brw_nx;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      brw_q <= 1'b0;
      bo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sh_q <= sh_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      brw_q <= brw_d;
      bo_q <= bo_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign r = r_q;
  assign bo = bo_q;
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed and random checks of sub_serial against an arithmetic reference.
module tb_sub_serial;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bi = 1'b0;
  logic [15:0] a = '0, b = '0, r;
  logic in_ready, out_valid, bo, busy;
  int checks = 0, failures = 0, cyc = 0, last_acc = -1;
  logic [15:0] prev_r = '0;
  logic prev_bo = 1'b0;

  sub_serial #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .bo(bo), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    a = 16'($urandom);
    b = 16'($urandom);
    bi = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbi,
                       input int stall, input bit noisy);
    logic [15:0] er;
    logic eb;
    int n, lat;
    er = 16'(int'(ta) - int'(tb_) - int'(tbi));
    eb = int'(ta) < int'(tb_) + int'(tbi);
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_before_accept", in_ready, 1);
    a = ta; b = tb_; bi = tbi; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    if (last_acc >= 0) chk("interval_ge_18", (cyc - last_acc) >= 18, 1);
    last_acc = cyc;
    chk("busy_after_accept", busy, 1);
    chk("in_ready_in_run", in_ready, 0);
    in_valid = noisy;
    if (noisy) scramble();
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("r_holds_prev_in_run", {15'b0, bo, r}, {15'b0, prev_bo, prev_r});
      tick();
      lat++;
      if (noisy) scramble();
    end
    chk("latency", lat, 16);
    chk("result_r", r, er);
    chk("result_bo", bo, eb);
    repeat (stall) begin
      tick();
      if (noisy) scramble();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_r_bo", {15'b0, bo, r}, {15'b0, eb, er});
    end
    out_ready = 1'b1;
    tick();
    chk("handshake_out_valid", out_valid, 0);
    chk("handshake_no_capture", busy, 0);
    chk("retain_r_bo", {15'b0, bo, r}, {15'b0, eb, er});
    out_ready = 1'b0;
    prev_r = er;
    prev_bo = eb;
  endtask

  initial begin
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_r_bo", {15'b0, bo, r}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_release", in_ready, 1);
    do_op(16'h0005, 16'h0003, 1'b0, 0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0, 0);
    do_op(16'h8000, 16'h8000, 1'b1, 0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 0);
    do_op(16'hA5A5, 16'h5A5A, 1'b0, 5, 1);
    do_op(16'h7FFF, 16'hFFFF, 1'b1, 1, 0);
    // Mid-RUN reset must wipe the prior result asynchronously.
    a = 16'hDEAD; b = 16'h0001; bi = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_r_bo", {15'b0, bo, r}, 0);
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    prev_r = '0;
    prev_bo = 1'b0;
    last_acc = -1;
    tick();
    chk("in_ready_after_midrun_reset", in_ready, 1);
    do_op(16'h1234, 16'h0234, 1'b0, 0, 0);
    for (int i = 0; i < 100; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
